// File: rtl/regfile_bypass_sb.sv
// rtl/regfile_bypass_sb.sv - register file with dual write-back, same-cycle bypass and busy scoreboard
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rd_addr / rd_data    NRD combinational read ports (packed, port i at i*AW / i*XLEN)
//   rd_busy              per-port busy flag of the addressed register
//   wr0_* / wr1_*        write-back ports (ALU / LSU); wr1 wins on an address clash
//   iss_en / iss_addr    mark a destination register busy
//   flush                clear all busy bits, contents untouched
//   any_busy             OR of the registered busy vector
module regfile_bypass_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic                any_busy
);

    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy;

    // Write-back enables with the zero register filtered out.
    logic wr0_hit;
    logic wr1_hit;
    logic iss_hit;

    assign wr0_hit = wr0_en && (wr0_addr != '0);
    assign wr1_hit = wr1_en && (wr1_addr != '0);
    assign iss_hit = iss_en && (iss_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                mem[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (wr1_hit && (wr1_addr == AW'(r))) begin
                    mem[r] <= wr1_data;
                end else if (wr0_hit && (wr0_addr == AW'(r))) begin
                    mem[r] <= wr0_data;
                end

                // A new producer issued in the same cycle as a retiring one
                // keeps the register busy; flush discards both.
                if (flush) begin
                    busy[r] <= 1'b0;
                end else if (iss_hit && (iss_addr == AW'(r))) begin
                    busy[r] <= 1'b1;
                end else if ((wr1_hit && (wr1_addr == AW'(r))) ||
                             (wr0_hit && (wr0_addr == AW'(r)))) begin
                    busy[r] <= 1'b0;
                end
            end
            busy[0] <= 1'b0;
        end
    end

    assign any_busy = |busy;

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = rd_addr[g*AW +: AW];

        // Reads are forced to zero while reset is held so that pending
        // write-back inputs cannot leak through the bypass.
        always_comb begin
            data = '0;
            bsy  = 1'b0;
            if (!rst_n || (addr == '0)) begin
                data = '0;
                bsy  = 1'b0;
            end else if (wr1_en && (wr1_addr == addr)) begin
                data = wr1_data;
            end else if (wr0_en && (wr0_addr == addr)) begin
                data = wr0_data;
            end else begin
                data = mem[addr];
                bsy  = busy[addr];
            end
        end

        assign rd_data[g*XLEN +: XLEN] = data;
        assign rd_busy[g]              = bsy;
    end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb/tb_regfile_bypass_sb.sv - table-driven self-checking bench for regfile_bypass_sb
module tb_regfile_bypass_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr0_en;
    logic [AW-1:0]       wr0_addr;
    logic [XLEN-1:0]     wr0_data;
    logic                wr1_en;
    logic [AW-1:0]       wr1_addr;
    logic [XLEN-1:0]     wr1_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic                any_busy;

    regfile_bypass_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr0_en   (wr0_en),
        .wr0_addr (wr0_addr),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (wr1_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .any_busy (any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w0e;
        logic [4:0]  w0a;
        logic [31:0] w0d;
        logic        w1e;
        logic [4:0]  w1a;
        logic [31:0] w1d;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
        logic        ea;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic vec_t mk(
        input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
        input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
        input logic ie, input logic [4:0] ia, input logic fl,
        input logic [4:0] ra0, input logic [4:0] ra1,
        input logic [31:0] e0, input logic [31:0] e1,
        input logic [1:0] eb, input logic ea);
        vec_t v;
        v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
        v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
        v.ie = ie; v.ia = ia; v.fl = fl;
        v.ra0 = ra0; v.ra1 = ra1;
        v.e0 = e0; v.e1 = e1; v.eb = eb; v.ea = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        wr0_en = 0; wr0_addr = '0; wr0_data = '0;
        wr1_en = 0; wr1_addr = '0; wr1_data = '0;
        iss_en = 0; iss_addr = '0; flush = 0;
    endtask

    task automatic run_vec(input int i);
        @(negedge clk);
        wr0_en = vecs[i].w0e; wr0_addr = vecs[i].w0a; wr0_data = vecs[i].w0d;
        wr1_en = vecs[i].w1e; wr1_addr = vecs[i].w1a; wr1_data = vecs[i].w1d;
        iss_en = vecs[i].ie;  iss_addr = vecs[i].ia;  flush = vecs[i].fl;
        rd_addr = {vecs[i].ra1, vecs[i].ra0};
        #2;
        check($sformatf("v%0d rd_data0", i), rd_data[31:0],  vecs[i].e0);
        check($sformatf("v%0d rd_data1", i), rd_data[63:32], vecs[i].e1);
        check($sformatf("v%0d rd_busy", i),  {30'd0, rd_busy}, {30'd0, vecs[i].eb});
        check($sformatf("v%0d any_busy", i), {31'd0, any_busy}, {31'd0, vecs[i].ea});
    endtask

    initial begin
        //             w0e w0a  w0d           w1e w1a  w1d           ie ia    fl ra0   ra1   e0            e1            eb     ea
        vecs[0]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd5, 5'd0, 32'h0,        32'h0,        2'b00, 0);
        vecs[1]  = mk(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
        vecs[2]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd8, 0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00, 0);
        vecs[3]  = mk(1, 5'd0, 32'h12345678, 0, 5'd0, 32'h0,        1, 5'd0, 0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 0);
        vecs[4]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 0);
        vecs[5]  = mk(1, 5'd7, 32'hAAAA0000, 1, 5'd7, 32'h0000BBBB, 0, 5'd0, 0, 5'd7, 5'd7, 32'h0000BBBB, 32'h0000BBBB, 2'b00, 0);
        vecs[6]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd7, 5'd0, 32'h0000BBBB, 32'h0,        2'b00, 0);
        vecs[7]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd3, 0, 5'd3, 5'd7, 32'h0,        32'h0000BBBB, 2'b00, 0);
        vecs[8]  = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd3, 5'd3, 32'h0,        32'h0,        2'b11, 1);
        vecs[9]  = mk(0, 5'd0, 32'h0,        1, 5'd3, 32'h55,       0, 5'd0, 0, 5'd3, 5'd3, 32'h55,       32'h55,       2'b00, 1);
        vecs[10] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd3, 5'd0, 32'h55,       32'h0,        2'b00, 0);
        vecs[11] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd9, 0, 5'd9, 5'd9, 32'h0,        32'h0,        2'b00, 0);
        vecs[12] = mk(1, 5'd9, 32'h77,       0, 5'd0, 32'h0,        1, 5'd9, 0, 5'd9, 5'd9, 32'h77,       32'h77,       2'b00, 1);
        vecs[13] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd9, 5'd9, 32'h77,       32'h77,       2'b11, 1);
        vecs[14] = mk(0, 5'd0, 32'h0,        1, 5'd9, 32'h99,       0, 5'd0, 0, 5'd9, 5'd3, 32'h99,       32'h55,       2'b00, 1);
        vecs[15] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd1, 0, 5'd1, 5'd2, 32'h0,        32'h0,        2'b00, 0);
        vecs[16] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd2, 0, 5'd1, 5'd2, 32'h0,        32'h0,        2'b01, 1);
        vecs[17] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd4, 0, 5'd1, 5'd2, 32'h0,        32'h0,        2'b11, 1);
        vecs[18] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd6, 1, 5'd4, 5'd6, 32'h0,        32'h0,        2'b01, 1);
        vecs[19] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd4, 5'd6, 32'h0,        32'h0,        2'b00, 0);
        vecs[20] = mk(1, 5'd5, 32'h1234,     0, 5'd0, 32'h0,        0, 5'd0, 1, 5'd5, 5'd9, 32'h1234,     32'h99,       2'b00, 0);
        vecs[21] = mk(0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 0, 5'd5, 5'd7, 32'h1234,     32'h0000BBBB, 2'b00, 0);

        rst_n = 0;
        drive_idle();
        rd_addr = {5'd0, 5'd5};
        repeat (3) @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 3; i++) run_vec(i);

        // Asynchronous reset between edges with r5 written and r8 busy.
        @(negedge clk);
        drive_idle();
        rd_addr = {5'd0, 5'd5};
        #1;
        check("pre_reset r5", rd_data[31:0], 32'hDEADBEEF);
        check("pre_reset any_busy", {31'd0, any_busy}, 32'd1);
        rst_n = 0;
        #1;
        check("in_reset r5", rd_data[31:0], 32'h0);
        check("in_reset any_busy", {31'd0, any_busy}, 32'd0);
        wr0_en = 1; wr0_addr = 5'd5; wr0_data = 32'hCAFE;
        iss_en = 1; iss_addr = 5'd5;
        #1;
        check("in_reset bypass gated", rd_data[31:0], 32'h0);
        check("in_reset rd_busy", {30'd0, rd_busy}, 32'd0);
        @(negedge clk);
        drive_idle();
        rst_n = 1;
        #1;
        check("post_reset r5", rd_data[31:0], 32'h0);
        check("post_reset any_busy", {31'd0, any_busy}, 32'd0);

        for (int i = 3; i < NV; i++) run_vec(i);

        @(negedge clk);
        drive_idle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_bypass_sb.md
# regfile_bypass_sb

Parametrised register file with a configurable number of read ports, two write-back ports, same-cycle write-to-read bypass, and a per-register busy scoreboard. It is the next-generation register file for the processor datapath. The decode stage reads operands and busy status from it. Issue marks destination registers busy. The two write-back paths (ALU and load/store) retire results and clear busy bits. Register 0 reads as zero and is never busy.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers, power of two, at least 2
- NRD, 2, number of read ports, 1..4
- AW, $clog2(NREG), register address width (derived, not overridden)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN]
- rd_busy  out  NRD  per-port busy flag for the addressed register
- wr0_en  in  1  write-back port 0 enable (ALU)
- wr0_addr  in  AW  write-back port 0 address
- wr0_data  in  XLEN  write-back port 0 data
- wr1_en  in  1  write-back port 1 enable (LSU)
- wr1_addr  in  AW  write-back port 1 address
- wr1_data  in  XLEN  write-back port 1 data
- iss_en  in  1  issue: mark iss_addr busy
- iss_addr  in  AW  destination register of the issuing instruction
- flush  in  1  clear all busy bits; register contents are unaffected
- any_busy  out  1  OR of all busy bits (registered state)

## Operation
- Storage: NREG x XLEN array plus NREG-bit busy vector. Entry 0 is never written, and busy[0] is held at 0.
- Writes take effect on the rising edge when wrX_en=1 and wrX_addr!=0.
- If both write ports target the same non-zero address in one cycle, wr1 wins.
- Read path is combinational, evaluated per port i with address a:
  - a==0 -> data 0, busy 0.
  - else wr1_en and wr1_addr==a -> data wr1_data, busy 0 (bypass).
  - else wr0_en and wr0_addr==a -> data wr0_data, busy 0 (bypass).
  - else array[a], busy[a].
- Busy update per edge, evaluated for each register r!=0, highest priority first:
  - flush=1 -> busy[r]=0; a coincident issue is also discarded.
  - iss_en and iss_addr==r -> busy[r]=1. This holds even if a write-back to r happens in the same cycle, because the new producer supersedes the retiring one. The data is still written.
  - write-back (either port) to r -> busy[r]=0.
  - otherwise hold.
- Issue to address 0 is ignored.
- flush does not block writes.
- any_busy reflects registered busy state only; there is no bypass on this output.

## Timing
- Reset (rst_n=0, asynchronous): all array entries 0, all busy bits 0. While in reset, rd_data=0 on all ports, rd_busy=0, any_busy=0.
- Reset asserted mid-operation clears state immediately, independent of clk. Pending write or issue inputs on the release edge are honoured only if rst_n is already 1 at that edge.
- Read latency: 0 cycles (combinational from rd_addr and write ports).
- Write-to-array latency: 1 edge. The value is visible via bypass in the same cycle and via the array from the next cycle.
- Issue-to-busy latency: 1 edge. rd_busy rises on the cycle after iss_en.
- Write-back clear: rd_busy drops in the same cycle as the write-back (bypass), and the registered bit clears at the edge.
- No handshake and no backpressure. Every enabled request is accepted each cycle.

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert rst_n=0 between edges -> rd_data(r5)=0 immediately and any_busy=0. After release, rd_data(r5)=0.
- Zero register: wr0 writes 0x12345678 to r0 and issue r0 -> every read port on r0 returns 0 with busy 0. any_busy stays 0.
- Bypass and dual-write conflict: same cycle wr0 (r7, 0xAAAA0000) and wr1 (r7, 0x0000BBBB) -> read r7 returns 0x0000BBBB that cycle and every later cycle.
- Scoreboard: issue r3, next cycle rd_busy(r3)=1 and any_busy=1. wr1 writes r3=0x55 -> same cycle rd_busy=0 and rd_data=0x55. Next cycle busy[r3]=0 and any_busy=0.
- Issue/write-back collision: r9 busy; same cycle wr0 to r9 (0x77) and issue r9 -> after the edge r9 holds 0x77 and busy[r9]=1.
- Flush: issue r1, r2, r4 on successive cycles, then flush together with issue r6 -> after the edge all busy bits are 0, any_busy=0, and register contents are unchanged.
